// File: rtl/exe_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module   : exe_issue_ctrl
// Purpose  : Execute-stage sequencer around the combinational FU: execute
//            register, issue/memory handshakes, delay-slot-aware redirect,
//            front-end flush and refill bubble.
//            Optional: define EXE_PERF_CNT_EN for branch/mispredict counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package exe_issue_pkg;
    typedef enum logic [2:0] {
        EXE_ALU    = 3'd0,
        EXE_BRANCH = 3'd1,
        EXE_LOAD   = 3'd2,
        EXE_STORE  = 3'd3
    } exe_type_t;

    typedef struct packed {
        exe_type_t   exe_type;
        logic [31:0] pc;
        logic [31:0] operand;
        logic [31:0] target;
    } fu_require_t;

    typedef struct packed {
        logic        enable;
        logic [31:0] pc_new;
    } pc_check_t;
endpackage

module exe_issue_ctrl
    import exe_issue_pkg::*;
#(
    parameter int BUBBLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  fu_require_t in_req,
    input  logic        in_valid,
    output logic        in_ready,
    output fu_require_t fu_req,
    input  pc_check_t   fu_check,
    output logic        mem_valid,
    input  logic        mem_ready,
    output pc_check_t   redirect,
    output logic        flush_front
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_BUBBLE_LOAD = CNT_W'(BUBBLE_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SLOT_WAIT = 2'd1,
        ST_REDIRECT  = 2'd2,
        ST_BUBBLE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ex_valid;
    fu_require_t        r_fu_req;
    logic [31:0]        r_pending_pc;
    logic [31:0]        w_pending_nxt;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic [CNT_W-1:0]   w_bubble_nxt;
    pc_check_t          r_redirect;
    logic               r_flush;
    logic               w_accept;
    logic               w_fire;
    logic               w_enter_redirect;

    // Gated by rst so issue sees no ready while the block is held in reset.
    assign in_ready  = !rst && (r_state == ST_RUN || r_state == ST_SLOT_WAIT)
                       && (!r_ex_valid || mem_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_fire    = r_ex_valid && mem_ready;
    assign mem_valid = r_ex_valid;
    assign fu_req    = r_fu_req;
    assign redirect  = r_redirect;
    assign flush_front = r_flush;
    assign w_enter_redirect = (w_state_nxt == ST_REDIRECT);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending_pc;
        w_bubble_nxt  = r_bubble_cnt;
        case (r_state)
            ST_RUN: begin
                // Only a retiring instruction in RUN may trigger a redirect.
                if (w_fire && fu_check.enable) begin
                    w_pending_nxt = fu_check.pc_new;
                    w_state_nxt   = w_accept ? ST_REDIRECT : ST_SLOT_WAIT;
                end
            end
            ST_SLOT_WAIT: begin
                if (w_accept) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                w_bubble_nxt = c_BUBBLE_LOAD;
                w_state_nxt  = (BUBBLE_CYCLES == 0) ? ST_RUN : ST_BUBBLE;
            end
            ST_BUBBLE: begin
                w_bubble_nxt = r_bubble_cnt - c_ONE;
                if (r_bubble_cnt <= c_ONE) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_ex_valid   <= 1'b0;
            r_fu_req     <= '0;
            r_pending_pc <= '0;
            r_bubble_cnt <= '0;
            r_redirect   <= '0;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending_pc <= w_pending_nxt;
            r_bubble_cnt <= w_bubble_nxt;
            if (w_accept) begin
                r_fu_req   <= in_req;
                r_ex_valid <= 1'b1;
            end else if (w_fire) begin
                r_ex_valid <= 1'b0;
            end
            r_redirect.enable <= w_enter_redirect;
            r_redirect.pc_new <= w_enter_redirect ? w_pending_nxt : 32'd0;
            r_flush           <= w_enter_redirect;
        end
    end

`ifdef EXE_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_fire && r_fu_req.exe_type == EXE_BRANCH) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_enter_redirect && r_state != ST_REDIRECT) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
`endif

endmodule

`default_nettype wire
